// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch front end: NOP encoding, word geometry,
// fetch FSM state encoding and the prefetch buffer entry layout.
package instruction_fetch_unit_pkg;

    // MOV R0,R0 -- also used by the decoder when a condition check fails.
    localparam logic [31:0] CPU_NOP_INSTR   = 32'hE1A0_0000;

    localparam int          WORD_W          = 32;
    localparam logic [31:0] WORD_BYTES      = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROOM,
        ST_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory read bus, redirect input and decoder handshake.
interface instruction_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        fe_redirect_en;
    logic [31:0] fe_redirect_addr;
    logic        fd_valid;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;
    logic        de_ready;

    modport master (
        output mem_req, mem_addr, fd_valid, fd_instruction, fd_pc,
        input  mem_rdata, mem_ack, fe_redirect_en, fe_redirect_addr, de_ready
    );

    modport slave (
        input  mem_req, mem_addr, fd_valid, fd_instruction, fd_pc,
        output mem_rdata, mem_ack, fe_redirect_en, fe_redirect_addr, de_ready
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous prefetch FIFO of {instruction, pc}; flush wins over push and pop,
// and the head comes straight from storage registers.
module fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  fetch_entry_t                  entry_in,
    input  logic                          pop,
    input  logic                          flush,
    output fetch_entry_t                  head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t           slot_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign count   = count_reg;
    assign head    = slot_reg[rd_ptr_reg];

    // Storage carries no reset; validity is tracked solely by count_reg.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slot_reg[wr_ptr_reg] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU fetch front end: sequential word fetch into a prefetch buffer, with
// redirect handling that drains an in-flight read before restarting.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] NOP_INSTR    = CPU_NOP_INSTR
) (
    input  logic                        clk,
    input  logic                        rst,
    instruction_fetch_unit_if.master    bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_reg;
    fetch_state_t       state_next;
    logic [31:0]        fetch_addr_reg;
    logic [31:0]        fetch_addr_next;
    logic [31:0]        hold_addr_reg;
    logic [31:0]        hold_addr_next;
    logic [31:0]        redirect_target;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    assign redirect_target = word_align(bus.fe_redirect_addr);
    assign pop             = !empty && bus.de_ready;
    assign push_entry      = '{instr: bus.mem_rdata, pc: fetch_addr_reg};

    // DRAIN keeps presenting the abandoned address until memory acknowledges it.
    assign bus.mem_req        = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign bus.mem_addr       = (state_reg == ST_DRAIN) ? hold_addr_reg : fetch_addr_reg;
    assign bus.fd_valid       = !empty;
    assign bus.fd_instruction = empty ? NOP_INSTR : head.instr;
    assign bus.fd_pc          = empty ? 32'h0 : head.pc;

    fetch_buffer #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .entry_in (push_entry),
        .pop      (pop),
        .flush    (bus.fe_redirect_en),
        .head     (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        hold_addr_next  = hold_addr_reg;
        push            = 1'b0;
        count_after     = count + CNT_W'(1) - (pop ? CNT_W'(1) : CNT_W'(0));

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.fe_redirect_en) begin
                    // An acked word is simply dropped; an unacked one must be drained.
                    if (!bus.mem_ack) begin
                        state_next     = ST_DRAIN;
                        hold_addr_next = fetch_addr_reg;
                    end
                end else if (bus.mem_ack) begin
                    push            = !full;
                    fetch_addr_next = fetch_addr_reg + WORD_BYTES;
                    state_next      = (count_after < CNT_W'(FIFO_DEPTH)) ? ST_FETCH : ST_WAIT_ROOM;
                end
            end
            ST_WAIT_ROOM: begin
                if (bus.fe_redirect_en || pop) begin
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (bus.mem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (bus.fe_redirect_en) begin
            fetch_addr_next = redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            fetch_addr_reg <= RESET_VECTOR;
            hold_addr_reg  <= RESET_VECTOR;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            hold_addr_reg  <= hold_addr_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle-by-cycle vector table
// followed by hand-written reset-restart and drain-overwrite sequences.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A0_0000;
    localparam int          NV  = 29;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        de;
        logic        redir;
        logic [31:0] raddr;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NV];

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FIFO_DEPTH   (2),
        .NOP_INSTR    (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic vec_t v(input logic r, input logic a, input logic [31:0] d,
                               input logic de, input logic re, input logic [31:0] ra,
                               input logic rq, input logic ca, input logic [31:0] ad,
                               input logic vl, input logic [31:0] p, input logic [31:0] ins);
        vec_t t;
        t.rst = r;   t.ack = a;       t.rdata = d;  t.de = de;   t.redir = re; t.raddr = ra;
        t.req = rq;  t.chk_addr = ca; t.addr = ad;  t.valid = vl; t.pc = p;    t.instr = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic [31:0] d,
                         input logic de, input logic re, input logic [31:0] ra);
        rst                  = r;
        bus.mem_ack          = a;
        bus.mem_rdata        = d;
        bus.de_ready         = de;
        bus.fe_redirect_en   = re;
        bus.fe_redirect_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;

        // Each row: inputs for this cycle, and outputs expected during this cycle.
        vecs[0]  = v(0,1'b0,32'h0,       1,0,32'h0,        0,1,32'h0,        0,32'h0,        NOP);
        vecs[1]  = v(0,1'b1,32'hC0DE0000,1,0,32'h0,        1,1,32'h0,        0,32'h0,        NOP);
        vecs[2]  = v(0,1'b1,32'hC0DE0004,1,0,32'h0,        1,1,32'h4,        1,32'h0,        32'hC0DE0000);
        vecs[3]  = v(0,1'b1,32'hC0DE0008,1,0,32'h0,        1,1,32'h8,        1,32'h4,        32'hC0DE0004);
        vecs[4]  = v(0,1'b0,32'h0,       1,0,32'h0,        1,1,32'hC,        1,32'h8,        32'hC0DE0008);
        vecs[5]  = v(0,1'b0,32'h0,       0,0,32'h0,        1,1,32'hC,        0,32'h0,        NOP);
        vecs[6]  = v(1,1'b0,32'h0,       0,0,32'h0,        1,1,32'hC,        0,32'h0,        NOP);
        vecs[7]  = v(0,1'b0,32'h0,       0,0,32'h0,        0,1,32'h0,        0,32'h0,        NOP);
        vecs[8]  = v(0,1'b1,32'hC0DE0000,0,0,32'h0,        1,1,32'h0,        0,32'h0,        NOP);
        vecs[9]  = v(0,1'b1,32'hC0DE0004,0,0,32'h0,        1,1,32'h4,        1,32'h0,        32'hC0DE0000);
        vecs[10] = v(0,1'b0,32'h0,       0,0,32'h0,        0,0,32'h0,        1,32'h0,        32'hC0DE0000);
        vecs[11] = v(0,1'b1,32'hDEADBEEF,1,0,32'h0,        0,0,32'h0,        1,32'h0,        32'hC0DE0000);
        vecs[12] = v(0,1'b0,32'h0,       0,0,32'h0,        1,1,32'h8,        1,32'h4,        32'hC0DE0004);
        vecs[13] = v(0,1'b0,32'h0,       0,1,32'h100,      1,1,32'h8,        1,32'h4,        32'hC0DE0004);
        vecs[14] = v(0,1'b0,32'h0,       0,0,32'h0,        1,1,32'h8,        0,32'h0,        NOP);
        vecs[15] = v(0,1'b1,32'hC0DE0008,0,0,32'h0,        1,1,32'h8,        0,32'h0,        NOP);
        vecs[16] = v(0,1'b1,32'hC0DE0100,0,0,32'h0,        1,1,32'h100,      0,32'h0,        NOP);
        vecs[17] = v(0,1'b0,32'h0,       1,0,32'h0,        1,1,32'h104,      1,32'h100,      32'hC0DE0100);
        vecs[18] = v(0,1'b1,32'hC0DE0104,0,0,32'h0,        1,1,32'h104,      0,32'h0,        NOP);
        vecs[19] = v(0,1'b1,32'hC0DE0108,1,1,32'h203,      1,1,32'h108,      1,32'h104,      32'hC0DE0104);
        vecs[20] = v(0,1'b0,32'h0,       1,0,32'h0,        1,1,32'h200,      0,32'h0,        NOP);
        vecs[21] = v(0,1'b1,32'hBADBAD00,1,1,32'hFFFFFFFF, 1,1,32'h200,      0,32'h0,        NOP);
        vecs[22] = v(0,1'b1,32'hC0DEFFFC,1,0,32'h0,        1,1,32'hFFFFFFFC, 0,32'h0,        NOP);
        vecs[23] = v(0,1'b1,32'hC0DE0000,0,0,32'h0,        1,1,32'h0,        1,32'hFFFFFFFC, 32'hC0DEFFFC);
        vecs[24] = v(0,1'b0,32'h0,       1,0,32'h0,        0,0,32'h0,        1,32'hFFFFFFFC, 32'hC0DEFFFC);
        vecs[25] = v(1,1'b0,32'h0,       0,0,32'h0,        1,1,32'h4,        1,32'h0,        32'hC0DE0000);
        vecs[26] = v(0,1'b0,32'h0,       0,0,32'h0,        0,1,32'h0,        0,32'h0,        NOP);
        vecs[27] = v(0,1'b1,32'hC0DE0000,0,0,32'h0,        1,1,32'h0,        0,32'h0,        NOP);
        vecs[28] = v(0,1'b0,32'h0,       0,0,32'h0,        1,1,32'h4,        1,32'h0,        32'hC0DE0000);

        drive(1, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].de, vecs[i].redir, vecs[i].raddr);
            $display("row %0d rst=%b ack=%b de=%b redir=%b | req=%b addr=%h valid=%b pc=%h instr=%h",
                     i, rst, bus.mem_ack, bus.de_ready, bus.fe_redirect_en,
                     bus.mem_req, bus.mem_addr, bus.fd_valid, bus.fd_pc, bus.fd_instruction);
            chk($sformatf("row%0d.mem_req", i), 32'(bus.mem_req), 32'(vecs[i].req));
            if (vecs[i].chk_addr) begin
                chk($sformatf("row%0d.mem_addr", i), bus.mem_addr, vecs[i].addr);
            end
            chk($sformatf("row%0d.fd_valid", i), 32'(bus.fd_valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d.fd_pc", i), bus.fd_pc, vecs[i].pc);
            chk($sformatf("row%0d.fd_instruction", i), bus.fd_instruction, vecs[i].instr);
            tick();
        end

        // Reset lands on the same edge as an ack with one word already buffered.
        drive(1, 1, 32'hC0DE0004, 0, 0, 32'h0);
        tick();
        $display("seq rst_mid_req | req=%b valid=%b pc=%h instr=%h",
                 bus.mem_req, bus.fd_valid, bus.fd_pc, bus.fd_instruction);
        chk("rst_mid_req.mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mid_req.fd_valid", 32'(bus.fd_valid), 32'h0);
        chk("rst_mid_req.fd_instruction", bus.fd_instruction, NOP);
        chk("rst_mid_req.fd_pc", bus.fd_pc, 32'h0);

        drive(0, 0, 32'h0, 0, 0, 32'h0);
        waited = 0;
        while (!bus.mem_req && waited < 5) begin
            tick();
            waited++;
        end
        $display("seq restart | waited=%0d req=%b addr=%h", waited, bus.mem_req, bus.mem_addr);
        chk("restart.mem_req", 32'(bus.mem_req), 32'h1);
        chk("restart.latency", 32'(waited), 32'h1);
        chk("restart.mem_addr", bus.mem_addr, 32'h0);

        // Two redirects while the read to 0 is unacked: address held, last target wins.
        drive(0, 0, 32'h0, 0, 1, 32'h300);
        tick();
        $display("seq drain1 | req=%b addr=%h valid=%b", bus.mem_req, bus.mem_addr, bus.fd_valid);
        chk("drain1.mem_req", 32'(bus.mem_req), 32'h1);
        chk("drain1.mem_addr", bus.mem_addr, 32'h0);
        drive(0, 0, 32'h0, 0, 1, 32'h402);
        tick();
        $display("seq drain2 | req=%b addr=%h valid=%b", bus.mem_req, bus.mem_addr, bus.fd_valid);
        chk("drain2.mem_addr", bus.mem_addr, 32'h0);
        drive(0, 1, 32'hC0DE0000, 0, 0, 32'h0);
        tick();
        $display("seq drain_ack | req=%b addr=%h valid=%b", bus.mem_req, bus.mem_addr, bus.fd_valid);
        chk("drain_ack.mem_req", 32'(bus.mem_req), 32'h1);
        chk("drain_ack.mem_addr", bus.mem_addr, 32'h400);
        chk("drain_ack.fd_valid", 32'(bus.fd_valid), 32'h0);
        drive(0, 1, 32'hC0DE0400, 1, 0, 32'h0);
        tick();
        $display("seq new_target | valid=%b pc=%h instr=%h", bus.fd_valid, bus.fd_pc, bus.fd_instruction);
        chk("new_target.fd_valid", 32'(bus.fd_valid), 32'h1);
        chk("new_target.fd_pc", bus.fd_pc, 32'h400);
        chk("new_target.fd_instruction", bus.fd_instruction, 32'hC0DE0400);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
